hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the IF/ID and ID/EX pipeline registers and decides every cycle whether the PC and IF/ID advance, and whether the ID/EX control fields are loaded from decode or zeroed into a bubble. It resolves four hazard sources: load-use, taken branch (resolved in EX), jump (resolved in ID) and data-memory busy freeze. It also keeps stall/flush statistics and a freeze watchdog.

---
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: decodes load-use, branch, jump and
// memory-busy hazards each cycle, and keeps stall/flush statistics plus a freeze watchdog.
module hazard_stall_ctrl #(
    parameter int unsigned MAX_FREEZE = 255,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IFIDUsesRt,
    input  logic             IDEXMemRead,
    input  logic [4:0]       IDEXDestReg,
    input  logic             branchTaken,
    input  logic             jumpID,
    input  logic             memBusy,
    output logic             pcWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             pipeFreeze,
    output logic [1:0]       ctrlState,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
    output logic             freezeTimeout
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLoadUse = 2'd1,
        StFlush   = 2'd2,
        StFreeze  = 2'd3
    } action_e;

    localparam logic [7:0]       MaxFreeze = 8'(MAX_FREEZE);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    logic             load_use;
    logic             flush_is_branch;
    action_e          action;

    action_e          ctrl_state_d, ctrl_state_q;
    logic [CNT_W-1:0] stall_count_d, stall_count_q;
    logic [CNT_W-1:0] flush_count_d, flush_count_q;
    logic [7:0]       freeze_run_d, freeze_run_q;
    logic             freeze_timeout_d, freeze_timeout_q;

    // A load into $0 is architecturally discarded, so it can never feed a dependent instruction.
    always_comb begin
        load_use = 1'b0;
        if (IDEXMemRead && (IDEXDestReg != 5'd0)) begin
            load_use = (IDEXDestReg == IFIDRs) || (IFIDUsesRt && (IDEXDestReg == IFIDRt));
        end
    end

    always_comb begin
        action          = StRun;
        flush_is_branch = 1'b0;
        if (memBusy) begin
            action = StFreeze;
        end else if (branchTaken) begin
            action          = StFlush;
            flush_is_branch = 1'b1;
        end else if (load_use) begin
            action = StLoadUse;
        end else if (jumpID) begin
            action = StFlush;
        end
    end

    always_comb begin
        pcWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        pipeFreeze = 1'b0;
        if (!resetN) begin
            pcWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else begin
            unique case (action)
                StFreeze: begin
                    pcWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    pipeFreeze = 1'b1;
                end
                StFlush: begin
                    IFIDFlush  = 1'b1;
                    // The jump in ID is a valid instruction and must proceed into EX.
                    IDEXBubble = flush_is_branch;
                end
                StLoadUse: begin
                    pcWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        ctrl_state_d  = action;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((action == StLoadUse) && (stall_count_q != CntMax)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if ((action == StFlush) && (flush_count_q != CntMax)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_comb begin
        freeze_run_d = 8'd0;
        if (memBusy) begin
            freeze_run_d = (freeze_run_q == MaxFreeze) ? freeze_run_q : freeze_run_q + 8'd1;
        end
        freeze_timeout_d = freeze_timeout_q || (freeze_run_d == MaxFreeze);
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            ctrl_state_q     <= StRun;
            stall_count_q    <= '0;
            flush_count_q    <= '0;
            freeze_run_q     <= 8'd0;
            freeze_timeout_q <= 1'b0;
        end else begin
            ctrl_state_q     <= ctrl_state_d;
            stall_count_q    <= stall_count_d;
            flush_count_q    <= flush_count_d;
            freeze_run_q     <= freeze_run_d;
            freeze_timeout_q <= freeze_timeout_d;
        end
    end

    assign ctrlState     = ctrl_state_q;
    assign stallCount    = stall_count_q;
    assign flushCount    = flush_count_q;
    assign freezeTimeout = freeze_timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed and randomized steps against a rule-level model, with a
// second instance using narrow counters and a short watchdog to reach saturation quickly.
module tb_hazard_stall_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetN;
    logic [4:0] rs, rt, dest;
    logic       uses_rt, mem_read, br, jmp, busy;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, freeze_timeout;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count, flush_count;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_freeze;
    logic        s_freeze_timeout;
    logic [1:0]  s_ctrl_state;
    logic [3:0]  s_stall_count, s_flush_count;

    hazard_stall_ctrl dut (
        .clock(clock), .resetN(resetN), .IFIDRs(rs), .IFIDRt(rt), .IFIDUsesRt(uses_rt),
        .IDEXMemRead(mem_read), .IDEXDestReg(dest), .branchTaken(br), .jumpID(jmp),
        .memBusy(busy), .pcWrite(pc_write), .IFIDWrite(ifid_write), .IFIDFlush(ifid_flush),
        .IDEXBubble(idex_bubble), .pipeFreeze(pipe_freeze), .ctrlState(ctrl_state),
        .stallCount(stall_count), .flushCount(flush_count), .freezeTimeout(freeze_timeout)
    );

    hazard_stall_ctrl #(.MAX_FREEZE(3), .CNT_W(4)) dut_sat (
        .clock(clock), .resetN(resetN), .IFIDRs(rs), .IFIDRt(rt), .IFIDUsesRt(uses_rt),
        .IDEXMemRead(mem_read), .IDEXDestReg(dest), .branchTaken(br), .jumpID(jmp),
        .memBusy(busy), .pcWrite(s_pc_write), .IFIDWrite(s_ifid_write),
        .IFIDFlush(s_ifid_flush), .IDEXBubble(s_idex_bubble), .pipeFreeze(s_pipe_freeze),
        .ctrlState(s_ctrl_state), .stallCount(s_stall_count), .flushCount(s_flush_count),
        .freezeTimeout(s_freeze_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Model state: plain event counts, saturated only when compared.
    int m_state   = 0;
    int m_stalls  = 0;
    int m_flushes = 0;
    int m_streak  = 0;
    bit m_tout    = 1'b0;
    bit m_tout_s  = 1'b0;

    // 0 run, 1 load-use, 2 branch flush, 3 freeze, 4 jump flush
    function automatic int model_action();
        bit hit;
        hit = mem_read && (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
        if (busy) return 3;
        if (br) return 2;
        if (hit) return 1;
        if (jmp) return 4;
        return 0;
    endfunction

    // {pcWrite, IFIDWrite, IFIDFlush, IDEXBubble, pipeFreeze}
    function automatic logic [4:0] model_outs(bit in_reset, int act);
        if (in_reset) return 5'b00110;
        case (act)
            1:       return 5'b00010;
            2:       return 5'b11110;
            3:       return 5'b00001;
            4:       return 5'b11100;
            default: return 5'b11000;
        endcase
    endfunction

    function automatic int sat(int v, int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit rn, input logic [4:0] a, input logic [4:0] b, input bit u,
                         input bit mr, input logic [4:0] d, input bit bt, input bit j,
                         input bit mb);
        resetN   = rn;
        rs       = a;
        rt       = b;
        uses_rt  = u;
        mem_read = mr;
        dest     = d;
        br       = bt;
        jmp      = j;
        busy     = mb;
    endtask

    task automatic drive_random(input bit allow_reset, input bit force_busy);
        drive(!(allow_reset && ($urandom_range(0, 99) == 0)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
              force_busy || ($urandom_range(0, 7) == 0));
    endtask

    task automatic step();
        int act;
        @(negedge clock);
        act = model_action();
        check("hazard_outs", {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze},
              model_outs(!resetN, act));
        check("hazard_outs_sat",
              {s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_freeze},
              model_outs(!resetN, act));
        @(posedge clock);
        if (!resetN) begin
            m_state   = 0;
            m_stalls  = 0;
            m_flushes = 0;
            m_streak  = 0;
            m_tout    = 1'b0;
            m_tout_s  = 1'b0;
        end else begin
            m_state = (act == 4) ? 2 : act;
            if (act == 1) m_stalls++;
            if (act == 2 || act == 4) m_flushes++;
            m_streak = busy ? m_streak + 1 : 0;
            if (m_streak >= 255) m_tout = 1'b1;
            if (m_streak >= 3) m_tout_s = 1'b1;
        end
        #1;
        check("ctrl_state", ctrl_state, m_state);
        check("stall_count", stall_count, sat(m_stalls, 65535));
        check("flush_count", flush_count, sat(m_flushes, 65535));
        check("freeze_timeout", freeze_timeout, m_tout);
        check("ctrl_state_sat", s_ctrl_state, m_state);
        check("stall_count_sat", s_stall_count, sat(m_stalls, 15));
        check("flush_count_sat", s_flush_count, sat(m_flushes, 15));
        check("freeze_timeout_sat", s_freeze_timeout, m_tout_s);
    endtask

    initial begin
        // Reset asserted while memory is busy.
        drive(0, 5'd1, 5'd2, 1, 1, 5'd1, 0, 0, 1);
        step();
        step();
        // Load-use on rs, then the bubble cycle.
        drive(1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0);
        step();
        drive(1, 5'd5, 5'd0, 0, 0, 5'd5, 0, 0, 0);
        step();
        // rt matches but is not a source; load into $0.
        drive(1, 5'd1, 5'd5, 0, 1, 5'd5, 0, 0, 0);
        step();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0);
        step();
        // Load-use on rt when used.
        drive(1, 5'd1, 5'd9, 1, 1, 5'd9, 0, 0, 0);
        step();
        // Branch overrides load-use and jump.
        drive(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0);
        step();
        // Jump alone, then jump behind a load-use.
        drive(1, 5'd3, 5'd4, 1, 0, 5'd0, 0, 1, 0);
        step();
        drive(1, 5'd6, 5'd4, 1, 1, 5'd6, 0, 1, 0);
        step();
        drive(1, 5'd6, 5'd4, 1, 0, 5'd6, 0, 1, 0);
        step();
        // Freeze over a pending load-use, then the load-use is seen once memory is free.
        drive(1, 5'd7, 5'd7, 1, 1, 5'd7, 1, 1, 1);
        repeat (3) step();
        drive(1, 5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0);
        step();
        // Reset in the middle of a stall abandons it.
        drive(0, 5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0);
        step();
        drive(1, 5'd2, 5'd3, 0, 0, 5'd7, 0, 0, 0);
        step();
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive_random(1, 0);
            step();
        end
        // Counter saturation: 20 load-use cycles from reset.
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        step();
        drive(1, 5'd4, 5'd0, 0, 1, 5'd4, 0, 0, 0);
        repeat (20) step();
        // Watchdog: 255 busy cycles, release, then clear only by reset.
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        step();
        for (int i = 0; i < 255; i++) begin
            drive_random(0, 1);
            step();
        end
        drive(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
        repeat (3) step();
        drive(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
        step();
        drive(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
